// File: rtl/turbo_frame_ctrl.sv
// rtl/turbo_frame_ctrl.sv - turbo encoder frame sequencer (optional abort: TURBO_CTRL_ABORT_EN)
module turbo_frame_ctrl #(
    parameter int KW    = 13,
    parameter int K_MIN = 40,
    parameter int K_MAX = 6144
) (
    input  logic          clk,
    input  logic          reset,
`ifdef TURBO_CTRL_ABORT_EN
    input  logic          abort,
`endif
    input  logic          start,
    input  logic [KW-1:0] k_len,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          enc_en,
    output logic          enc_clr,
    output logic          tailbits,
    output logic          tail_phase,
    output logic          out_valid,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [KW-1:0] bit_cnt
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_DATA = 3'd2,
        S_TAIL = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [KW-1:0] KMIN_W = KW'(K_MIN);
    localparam logic [KW-1:0] KMAX_W = KW'(K_MAX);

    state_t        r_state;
    state_t        w_next;
    logic [1:0]    r_tail_cnt;
    logic [KW-1:0] r_k_reg;
    logic [KW-1:0] r_bit_cnt;
    logic          r_enc_clr;
    logic          r_tail_phase;
    logic          r_busy;
    logic          r_done;
    logic          r_err;

    logic          w_legal;
    logic          w_accept;
    logic          w_reject;
    logic          w_beat;
    logic          w_last_beat;
    logic          w_abort;

    // Block length must be in range and a multiple of 8 (interleaver granularity).
    assign w_legal     = (k_len >= KMIN_W) && (k_len <= KMAX_W) && (k_len[2:0] == 3'b000);
    assign w_accept    = (r_state == S_IDLE) && start && w_legal;
    assign w_reject    = (r_state == S_IDLE) && start && !w_legal;
    assign w_beat      = (r_state == S_DATA) && in_valid;
    assign w_last_beat = w_beat && (r_bit_cnt == (r_k_reg - 1'b1));

`ifdef TURBO_CTRL_ABORT_EN
    assign w_abort = abort && (r_state != S_IDLE);
`else
    assign w_abort = 1'b0;
`endif

    assign bit_cnt    = r_bit_cnt;
    assign enc_clr    = r_enc_clr;
    assign tail_phase = r_tail_phase;
    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;

    // Next-state decode plus the combinational handshake and encoder strobes.
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        enc_en    = 1'b0;
        out_valid = 1'b0;
        tailbits  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = S_LOAD;
                end
            end
            S_LOAD: begin
                w_next = S_DATA;
            end
            S_DATA: begin
                in_ready = 1'b1;
                if (w_beat) begin
                    enc_en    = 1'b1;
                    out_valid = 1'b1;
                end
                if (w_last_beat) begin
                    // An abort on the final beat wins, so the tail processor is never triggered.
                    tailbits = !w_abort;
                    w_next   = S_TAIL;
                end
            end
            S_TAIL: begin
                out_valid = 1'b1;
                // Three shifts terminate the trellis; the fourth tail cycle only emits output.
                enc_en    = (r_tail_cnt != 2'd3);
                if (r_tail_cnt == 2'd3) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        if (w_abort) begin
            w_next = S_IDLE;
        end
    end

    // State register, tail counter, latched length and accepted-bit counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_tail_cnt <= 2'd0;
            r_k_reg    <= '0;
            r_bit_cnt  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_TAIL) begin
                r_tail_cnt <= r_tail_cnt + 2'd1;
            end else begin
                r_tail_cnt <= 2'd0;
            end
            if (w_accept) begin
                r_k_reg <= k_len;
            end
            if (w_abort || w_accept) begin
                r_bit_cnt <= '0;
            end else if (w_beat) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
        end
    end

    // Registered status outputs, decoded from the state being entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_enc_clr    <= 1'b0;
            r_tail_phase <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_enc_clr    <= (w_next == S_LOAD);
            r_tail_phase <= (w_next == S_TAIL);
            r_busy       <= (w_next != S_IDLE);
            r_done       <= (w_next == S_DONE);
            r_err        <= w_reject;
        end
    end

endmodule

// File: tb/tb_turbo_frame_ctrl.sv
// tb/tb_turbo_frame_ctrl.sv - directed self-checking bench for turbo_frame_ctrl
module tb_turbo_frame_ctrl;

    localparam int KW = 13;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [KW-1:0] k_len;
    logic          in_valid;
    logic          in_ready;
    logic          enc_en;
    logic          enc_clr;
    logic          tailbits;
    logic          tail_phase;
    logic          out_valid;
    logic          busy;
    logic          done;
    logic          err;
    logic [KW-1:0] bit_cnt;
`ifdef TURBO_CTRL_ABORT_EN
    logic          abort;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    int clr_cnt, clr_cyc, beats, first_beat, tb_cnt, tb_cyc, tb_beat;
    int tp_cnt, tp_first, last_tp_en, en_cnt, done_cnt, done_cyc, done_bitcnt;
    int err_cnt, idle_cyc;

    int bad_k [3];

    turbo_frame_ctrl #(.KW(KW), .K_MIN(40), .K_MAX(6144)) dut (
        .clk        (clk),
        .reset      (reset),
`ifdef TURBO_CTRL_ABORT_EN
        .abort      (abort),
`endif
        .start      (start),
        .k_len      (k_len),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .enc_en     (enc_en),
        .enc_clr    (enc_clr),
        .tailbits   (tailbits),
        .tail_phase (tail_phase),
        .out_valid  (out_valid),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .bit_cnt    (bit_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Start one frame at cycle 0 and record event cycles for cycles 1..ncyc.
    task automatic run_frame(input int k, input bit gap, input int sp1, input int sp2,
                             input int ncyc, input int abort_bit);
        bit aborted;
        aborted = 1'b0;
        clr_cnt = 0; clr_cyc = -1; beats = 0; first_beat = -1; tb_cnt = 0; tb_cyc = -1;
        tb_beat = -1; tp_cnt = 0; tp_first = -1; last_tp_en = -1; en_cnt = 0;
        done_cnt = 0; done_cyc = -1; done_bitcnt = -1; err_cnt = 0; idle_cyc = -1;
        @(posedge clk); #1;
        start    = 1'b1;
        k_len    = KW'(k);
        in_valid = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk); #1;
            start    = (c == sp1) || (c == sp2);
            in_valid = gap ? ((c % 3) != 0) : 1'b1;
`ifdef TURBO_CTRL_ABORT_EN
            abort = 1'b0;
            if (abort_bit >= 0 && !aborted && busy && (int'(bit_cnt) == abort_bit)) begin
                abort   = 1'b1;
                aborted = 1'b1;
            end
`else
            if (abort_bit >= 0) aborted = 1'b1;
`endif
            @(negedge clk);
            if (enc_clr) begin clr_cnt++; if (clr_cyc < 0) clr_cyc = c; end
            if (in_ready && in_valid) begin beats++; if (first_beat < 0) first_beat = c; end
            if (tailbits) begin tb_cnt++; tb_cyc = c; tb_beat = beats; end
            if (tail_phase) begin tp_cnt++; if (tp_first < 0) tp_first = c; last_tp_en = int'(enc_en); end
            if (enc_en) en_cnt++;
            if (done) begin done_cnt++; done_cyc = c; done_bitcnt = int'(bit_cnt); end
            if (err) err_cnt++;
            if (!busy && idle_cyc < 0) idle_cyc = c;
        end
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b0;
`ifdef TURBO_CTRL_ABORT_EN
        abort    = 1'b0;
`endif
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        k_len    = '0;
`ifdef TURBO_CTRL_ABORT_EN
        abort    = 1'b0;
`endif
        bad_k[0] = 44;
        bad_k[1] = 32;
        bad_k[2] = 6152;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", {in_ready, enc_en, enc_clr, tailbits, tail_phase, out_valid,
                           busy, done, err}, 32'd0);
        chk("reset_bitcnt", bit_cnt, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // K=40, in_valid high, start pulses in DATA (cycle 10) and TAIL (cycle 44) ignored
        run_frame(40, 1'b0, 10, 44, 60, -1);
        chk("k40_clr_cyc", clr_cyc, 32'd1);
        chk("k40_clr_cnt", clr_cnt, 32'd1);
        chk("k40_first_beat", first_beat, 32'd2);
        chk("k40_beats", beats, 32'd40);
        chk("k40_tb_cyc", tb_cyc, 32'd41);
        chk("k40_tb_cnt", tb_cnt, 32'd1);
        chk("k40_tp_first", tp_first, 32'd42);
        chk("k40_tp_cnt", tp_cnt, 32'd4);
        chk("k40_en_last_tail", last_tp_en, 32'd0);
        chk("k40_en_cnt", en_cnt, 32'd43);
        chk("k40_done_cyc", done_cyc, 32'd46);
        chk("k40_done_cnt", done_cnt, 32'd1);
        chk("k40_done_bitcnt", done_bitcnt, 32'd40);
        chk("k40_idle_cyc", idle_cyc, 32'd47);
        chk("k40_hold_bitcnt", bit_cnt, 32'd40);

        // K=48, in_valid low every third cycle: beats at c%3!=0, 48th beat at cycle 73
        run_frame(48, 1'b1, -1, -1, 90, -1);
        chk("k48_beats", beats, 32'd48);
        chk("k48_tb_beat", tb_beat, 32'd48);
        chk("k48_tb_cyc", tb_cyc, 32'd73);
        chk("k48_done_cyc", done_cyc, 32'd78);
        chk("k48_done_bitcnt", done_bitcnt, 32'd48);
        chk("k48_clr_cnt", clr_cnt, 32'd1);

        // Illegal lengths: err one cycle later, no frame started
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            start = 1'b1;
            k_len = KW'(bad_k[i]);
            @(negedge clk);
            chk("bad_err_c0", err, 32'd0);
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            chk("bad_err_c1", err, 32'd1);
            chk("bad_busy_c1", busy, 32'd0);
            chk("bad_clr_c1", enc_clr, 32'd0);
            @(posedge clk); #1;
            @(negedge clk);
            chk("bad_err_c2", err, 32'd0);
            chk("bad_busy_c2", busy, 32'd0);
        end

        // Reset at bit 20 of a K=40 frame
        @(posedge clk); #1;
        start    = 1'b1;
        k_len    = KW'(40);
        in_valid = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 100 && bit_cnt != KW'(20); i++) begin
            @(posedge clk); #1;
        end
        chk("rst_reach20", bit_cnt, 32'd20);
        reset = 1'b1;
        #1;
        chk("rst_async_outs", {in_ready, enc_en, enc_clr, tailbits, tail_phase, out_valid,
                               busy, done, err}, 32'd0);
        chk("rst_async_bitcnt", bit_cnt, 32'd0);
        @(posedge clk); #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        run_frame(40, 1'b0, -1, -1, 50, -1);
        chk("post_rst_beats", beats, 32'd40);
        chk("post_rst_done_cyc", done_cyc, 32'd46);
        chk("post_rst_done_cnt", done_cnt, 32'd1);

`ifdef TURBO_CTRL_ABORT_EN
        // Abort at bit 10 (cycle 12): idle from cycle 13, no tailbits or done
        run_frame(40, 1'b0, -1, -1, 60, 10);
        chk("abort_idle_cyc", idle_cyc, 32'd13);
        chk("abort_tb_cnt", tb_cnt, 32'd0);
        chk("abort_done_cnt", done_cnt, 32'd0);
        chk("abort_bitcnt", bit_cnt, 32'd0);
        chk("abort_busy", busy, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
